// File: rtl/hsid_min_dist_sel.sv
// Minimum/maximum distance selector: tracks best and worst library match per pixel
// and emits a one-cycle result pulse after the last reference of the frame.
module hsid_min_dist_sel #(
    parameter int DATA_WIDTH_ACC    = 32,
    parameter int HSP_LIBRARY_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic [HSP_LIBRARY_WIDTH-1:0] library_size,
    input  logic                         acc_valid,
    input  logic [DATA_WIDTH_ACC-1:0]    acc_value,
    input  logic                         acc_last,
    input  logic [HSP_LIBRARY_WIDTH-1:0] acc_ref,
    input  logic                         acc_of,
    output logic                         busy,
    output logic                         result_valid,
    output logic [DATA_WIDTH_ACC-1:0]    min_value,
    output logic [HSP_LIBRARY_WIDTH-1:0] min_ref,
    output logic [DATA_WIDTH_ACC-1:0]    max_value,
    output logic [HSP_LIBRARY_WIDTH-1:0] max_ref,
    output logic                         result_of
);

    localparam int CW = HSP_LIBRARY_WIDTH + 1;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                         state, state_nxt;
    logic                           acc_of_q;
    logic                           of_rise;
    logic                           cand;
    logic [DATA_WIDTH_ACC-1:0]      cand_val;
    logic [CW-1:0]                  lib_eff;
    logic [CW-1:0]                  cnt, cnt_nxt;
    logic [CW-1:0]                  lib_n, lib_n_nxt;
    logic [DATA_WIDTH_ACC-1:0]      min_w, min_nxt, max_w, max_nxt;
    logic [HSP_LIBRARY_WIDTH-1:0]   min_ref_w, min_ref_nxt, max_ref_w, max_ref_nxt;
    logic                           of_w, of_nxt;
    logic                           done;

    // An overflowed distance is pinned to the largest representable value.
    function automatic logic [DATA_WIDTH_ACC-1:0] sat_value(
        input logic                      of,
        input logic [DATA_WIDTH_ACC-1:0] value
    );
        return of ? '1 : value;
    endfunction

    assign of_rise  = acc_of && !acc_of_q;
    assign cand     = ((acc_valid && acc_last) || of_rise) && !clear;
    assign cand_val = sat_value(acc_of, acc_value);
    assign lib_eff  = (library_size == '0) ? CW'(1) : {1'b0, library_size};
    assign busy     = (state == SCAN);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        lib_n_nxt   = lib_n;
        min_nxt     = min_w;
        min_ref_nxt = min_ref_w;
        max_nxt     = max_w;
        max_ref_nxt = max_ref_w;
        of_nxt      = of_w;
        done        = 1'b0;

        case (state)
            IDLE: begin
                if (cand) begin
                    min_nxt     = cand_val;
                    min_ref_nxt = acc_ref;
                    max_nxt     = cand_val;
                    max_ref_nxt = acc_ref;
                    cnt_nxt     = CW'(1);
                    of_nxt      = acc_of;
                    lib_n_nxt   = lib_eff;
                    if (lib_eff == CW'(1)) begin
                        done = 1'b1;
                    end else begin
                        state_nxt = SCAN;
                    end
                end
            end
            SCAN: begin
                if (cand) begin
                    cnt_nxt = cnt + CW'(1);
                    of_nxt  = of_w | acc_of;
                    // Strict compares: on ties the earlier reference wins.
                    if (cand_val < min_w) begin
                        min_nxt     = cand_val;
                        min_ref_nxt = acc_ref;
                    end
                    if (cand_val > max_w) begin
                        max_nxt     = cand_val;
                        max_ref_nxt = acc_ref;
                    end
                    if (cnt_nxt == lib_n) begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (clear) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            of_nxt    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            acc_of_q     <= 1'b0;
            cnt          <= '0;
            lib_n        <= '0;
            min_w        <= '0;
            min_ref_w    <= '0;
            max_w        <= '0;
            max_ref_w    <= '0;
            of_w         <= 1'b0;
            result_valid <= 1'b0;
            min_value    <= '0;
            min_ref      <= '0;
            max_value    <= '0;
            max_ref      <= '0;
            result_of    <= 1'b0;
        end else begin
            state        <= state_nxt;
            acc_of_q     <= acc_of;
            cnt          <= cnt_nxt;
            lib_n        <= lib_n_nxt;
            min_w        <= min_nxt;
            min_ref_w    <= min_ref_nxt;
            max_w        <= max_nxt;
            max_ref_w    <= max_ref_nxt;
            of_w         <= of_nxt;
            result_valid <= done;
            // Result registers hold between completions, including across clear.
            if (done) begin
                min_value <= min_nxt;
                min_ref   <= min_ref_nxt;
                max_value <= max_nxt;
                max_ref   <= max_ref_nxt;
                result_of <= of_nxt;
            end
        end
    end

endmodule

// File: tb/tb_hsid_min_dist_sel.sv
// Bench for hsid_min_dist_sel: vector table plus scoreboard of expected result pulses.
module tb_hsid_min_dist_sel;

    localparam int DW = 16;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst, clear, acc_valid, acc_last, acc_of;
    logic [LW-1:0] library_size, acc_ref;
    logic [DW-1:0] acc_value;
    logic          busy, result_valid, result_of;
    logic [DW-1:0] min_value, max_value;
    logic [LW-1:0] min_ref, max_ref;

    hsid_min_dist_sel #(.DATA_WIDTH_ACC(DW), .HSP_LIBRARY_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .clear(clear), .library_size(library_size),
        .acc_valid(acc_valid), .acc_value(acc_value), .acc_last(acc_last),
        .acc_ref(acc_ref), .acc_of(acc_of), .busy(busy), .result_valid(result_valid),
        .min_value(min_value), .min_ref(min_ref), .max_value(max_value),
        .max_ref(max_ref), .result_of(result_of)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LW-1:0] lib;
        logic          v, l, o, c;
        logic [LW-1:0] r;
        logic [DW-1:0] d;
        logic          eb;
        logic          er;
        logic [DW-1:0] emin;
        logic [LW-1:0] eminr;
        logic [DW-1:0] emax;
        logic [LW-1:0] emaxr;
        logic          eof;
    } vec_t;

    typedef struct {
        int            due;
        logic [DW-1:0] mn;
        logic [LW-1:0] mr;
        logic [DW-1:0] mx;
        logic [LW-1:0] xr;
        logic          o;
    } exp_t;

    localparam logic [DW-1:0] ONES = '1;

    vec_t vecs[$];
    exp_t exp_q[$];
    exp_t held;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t mk(input logic [LW-1:0] lib, input logic v, input logic l,
                                input logic o, input logic c, input logic [LW-1:0] r,
                                input logic [DW-1:0] d, input logic eb);
        vec_t x;
        x.lib = lib; x.v = v; x.l = l; x.o = o; x.c = c; x.r = r; x.d = d; x.eb = eb;
        x.er = 1'b0; x.emin = '0; x.eminr = '0; x.emax = '0; x.emaxr = '0; x.eof = 1'b0;
        return x;
    endfunction

    function automatic vec_t cnd(input logic [LW-1:0] lib, input logic [LW-1:0] r,
                                 input logic [DW-1:0] d, input logic eb);
        return mk(lib, 1'b1, 1'b1, 1'b0, 1'b0, r, d, eb);
    endfunction

    function automatic vec_t fin(input logic [LW-1:0] lib, input logic [LW-1:0] r,
                                 input logic [DW-1:0] d, input logic [DW-1:0] emin,
                                 input logic [LW-1:0] eminr, input logic [DW-1:0] emax,
                                 input logic [LW-1:0] emaxr, input logic eof);
        vec_t x;
        x = mk(lib, 1'b1, 1'b1, 1'b0, 1'b0, r, d, 1'b0);
        x.er = 1'b1; x.emin = emin; x.eminr = eminr; x.emax = emax; x.emaxr = emaxr; x.eof = eof;
        return x;
    endfunction

    function automatic vec_t idl();
        return mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0, 1'b0);
    endfunction

    task automatic drive(input vec_t x);
        library_size = x.lib; acc_valid = x.v; acc_last = x.l; acc_of = x.o;
        clear = x.c; acc_ref = x.r; acc_value = x.d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every pulse must match the queue head on its due cycle; otherwise outputs hold.
    always @(negedge clk) begin
        if (mon_en) begin
            if (result_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_result: result_valid=1 at cycle %0d, required 0", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.due != cyc || min_value !== e.mn || min_ref !== e.mr ||
                        max_value !== e.mx || max_ref !== e.xr || result_of !== e.o) begin
                        n_fail++;
                        $display("FAIL result: got cyc=%0d min=%0d@%0d max=%0d@%0d of=%0d, required cyc=%0d min=%0d@%0d max=%0d@%0d of=%0d",
                                 cyc, min_value, min_ref, max_value, max_ref, result_of,
                                 e.due, e.mn, e.mr, e.mx, e.xr, e.o);
                    end
                    held = e;
                end
            end else begin
                n_cmp++;
                if (min_value !== held.mn || min_ref !== held.mr || max_value !== held.mx ||
                    max_ref !== held.xr || result_of !== held.o) begin
                    n_fail++;
                    $display("FAIL hold: cycle %0d got min=%0d@%0d max=%0d@%0d of=%0d, required min=%0d@%0d max=%0d@%0d of=%0d",
                             cyc, min_value, min_ref, max_value, max_ref, result_of,
                             held.mn, held.mr, held.mx, held.xr, held.o);
                end
            end
        end
    end

    task automatic check_zero(input string name);
        n_cmp++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || min_value !== '0 || min_ref !== '0 ||
            max_value !== '0 || max_ref !== '0 || result_of !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got busy=%0d rv=%0d min=%0d@%0d max=%0d@%0d of=%0d, required all 0",
                     name, busy, result_valid, min_value, min_ref, max_value, max_ref, result_of);
        end
    endtask

    task automatic check_busy(input string name, input logic eb);
        n_cmp++;
        if (busy !== eb) begin
            n_fail++;
            $display("FAIL %s: cycle %0d busy=%0d, required %0d", name, cyc, busy, eb);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        held = '{due: 0, mn: '0, mr: '0, mx: '0, xr: '0, o: 1'b0};
        rst = 1'b1;
        drive(idl());
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_state");
        rst = 1'b0;
        mon_en = 1'b1;

        // Basic min/max with a tie on the minimum
        vecs.push_back(cnd(4'd4, 4'd0, 16'd100, 1'b1));
        vecs.push_back(cnd(4'd4, 4'd1, 16'd40, 1'b1));
        vecs.push_back(cnd(4'd4, 4'd2, 16'd40, 1'b1));
        vecs.push_back(fin(4'd4, 4'd3, 16'd70, 16'd40, 4'd1, 16'd100, 4'd0, 1'b0));
        vecs.push_back(idl());
        // Non-last ignored, overflow rising edge saturates
        vecs.push_back(mk(4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'd5, 1'b0));
        vecs.push_back(cnd(4'd3, 4'd0, 16'd20, 1'b1));
        vecs.push_back(mk(4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 16'd0, 1'b1));
        vecs.push_back(fin(4'd3, 4'd2, 16'd30, 16'd20, 4'd0, ONES, 4'd1, 1'b1));
        vecs.push_back(idl());
        // acc_of held three cycles is one candidate
        vecs.push_back(mk(4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 16'd0, 1'b1));
        vecs.push_back(mk(4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 16'd0, 1'b1));
        vecs.push_back(mk(4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 16'd0, 1'b1));
        vecs.push_back(fin(4'd2, 4'd4, 16'd9, 16'd9, 4'd4, ONES, 4'd3, 1'b1));
        vecs.push_back(idl());
        // Single reference, library_size 1 and 0
        vecs.push_back(fin(4'd1, 4'd5, 16'd77, 16'd77, 4'd5, 16'd77, 4'd5, 1'b0));
        vecs.push_back(idl());
        vecs.push_back(fin(4'd0, 4'd5, 16'd77, 16'd77, 4'd5, 16'd77, 4'd5, 1'b0));
        vecs.push_back(idl());
        // Clear mid-frame, then a fresh full frame
        vecs.push_back(cnd(4'd4, 4'd0, 16'd1, 1'b1));
        vecs.push_back(cnd(4'd4, 4'd1, 16'd2, 1'b1));
        vecs.push_back(mk(4'd4, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 16'd0, 1'b0));
        vecs.push_back(cnd(4'd4, 4'd0, 16'd9, 1'b1));
        vecs.push_back(cnd(4'd4, 4'd1, 16'd8, 1'b1));
        vecs.push_back(cnd(4'd4, 4'd2, 16'd7, 1'b1));
        vecs.push_back(fin(4'd4, 4'd3, 16'd6, 16'd6, 4'd3, 16'd9, 4'd0, 1'b0));
        vecs.push_back(idl());
        // Clear together with the final candidate
        vecs.push_back(cnd(4'd2, 4'd0, 16'd5, 1'b1));
        vecs.push_back(mk(4'd2, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 16'd6, 1'b0));
        vecs.push_back(idl());
        // Back-to-back frames
        vecs.push_back(cnd(4'd2, 4'd0, 16'd10, 1'b1));
        vecs.push_back(fin(4'd2, 4'd1, 16'd3, 16'd3, 4'd1, 16'd10, 4'd0, 1'b0));
        vecs.push_back(cnd(4'd2, 4'd0, 16'd50, 1'b1));
        vecs.push_back(fin(4'd2, 4'd1, 16'd60, 16'd50, 4'd0, 16'd60, 4'd1, 1'b0));
        vecs.push_back(idl());

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            if (vecs[i].er)
                exp_q.push_back('{due: cyc + 1, mn: vecs[i].emin, mr: vecs[i].eminr,
                                  mx: vecs[i].emax, xr: vecs[i].emaxr, o: vecs[i].eof});
            step();
            check_busy($sformatf("busy_vec%0d", i), vecs[i].eb);
        end

        // Reset two candidates into a four-reference frame
        drive(cnd(4'd4, 4'd0, 16'd11, 1'b1));
        step();
        check_busy("busy_pre_rst0", 1'b1);
        drive(cnd(4'd4, 4'd1, 16'd22, 1'b1));
        step();
        check_busy("busy_pre_rst1", 1'b1);
        drive(idl());
        rst = 1'b1;
        step();
        held = '{due: 0, mn: '0, mr: '0, mx: '0, xr: '0, o: 1'b0};
        check_zero("reset_mid_frame");
        rst = 1'b0;
        // The remaining two references must start a new frame, not finish the old one
        drive(cnd(4'd4, 4'd2, 16'd33, 1'b1));
        step();
        check_busy("busy_post_rst0", 1'b1);
        drive(cnd(4'd4, 4'd3, 16'd44, 1'b1));
        step();
        check_busy("busy_post_rst1", 1'b1);
        drive(mk(4'd4, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 16'd0, 1'b0));
        step();
        check_busy("busy_after_clear", 1'b0);
        drive(idl());
        repeat (4) step();

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_results: %0d expected pulses never seen, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
